// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: DEPTH-entry instruction FIFO, head decoder and load-use bubble.
// Optional performance counters (cnt_issued, cnt_bubble) are built when PERF_CNT_EN is defined.
module decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_aluop,
    output logic [2:0]  id_cmpop,
    output logic        id_alumux1_sel,
    output logic [2:0]  id_alumux2_sel,
    output logic        id_cmpmux_sel,
    output logic [2:0]  id_regfilemux_sel,
    output logic [1:0]  id_pcmux_sel,
    output logic        id_load_regfile,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic [2:0]  id_funct3,
    output logic        id_illegal
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_issued,
    output logic [CNT_W-1:0] cnt_bubble
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
        $error("decode_queue: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpReg   = 7'b0110011;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSll = 3'd1;
    localparam logic [2:0] AluSra = 3'd2;
    localparam logic [2:0] AluSub = 3'd3;
    localparam logic [2:0] AluXor = 3'd4;
    localparam logic [2:0] AluSrl = 3'd5;
    localparam logic [2:0] AluOr  = 3'd6;
    localparam logic [2:0] AluAnd = 3'd7;

    localparam logic [2:0] CmpBlt  = 3'b100;
    localparam logic [2:0] CmpBltu = 3'b110;

    localparam logic [2:0] Mux2Iimm = 3'd0;
    localparam logic [2:0] Mux2Uimm = 3'd1;
    localparam logic [2:0] Mux2Bimm = 3'd2;
    localparam logic [2:0] Mux2Simm = 3'd3;
    localparam logic [2:0] Mux2Jimm = 3'd4;
    localparam logic [2:0] Mux2Rs2  = 3'd5;

    localparam logic [2:0] RfAlu   = 3'd0;
    localparam logic [2:0] RfBrEn  = 3'd1;
    localparam logic [2:0] RfUimm  = 3'd2;
    localparam logic [2:0] RfLoad  = 3'd3;
    localparam logic [2:0] RfPc4   = 3'd4;

    localparam logic [1:0] PcPlus4  = 2'd0;
    localparam logic [1:0] PcBranch = 2'd1;
    localparam logic [1:0] PcJalr   = 2'd2;

    // Storage and queue state
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     pc_mem_q    [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            lu_armed_q, lu_armed_d;
    logic [4:0]      lu_rd_q, lu_rd_d;

    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic        head_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rs1, rs2, rd;

    logic [2:0] dec_aluop, dec_cmpop, dec_alumux2, dec_rfmux;
    logic       dec_alumux1, dec_cmpmux, dec_load_rf, dec_mem_read, dec_mem_write, dec_illegal;
    logic [1:0] dec_pcmux;
    logic       uses_rs1, uses_rs2, is_load;
    logic       bubble, push, pop;

    function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3, input logic alt,
                                                   input logic is_reg);
        logic [2:0] op;
        case (f3)
            3'b000:  op = (alt && is_reg) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            3'b111:  op = AluAnd;
            default: op = AluAdd;
        endcase
        return op;
    endfunction

    assign head_instr = instr_mem_q[rd_ptr_q];
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign opcode     = head_instr[6:0];
    assign funct3     = head_instr[14:12];
    assign funct7_5   = head_instr[30];
    assign rs1        = head_instr[19:15];
    assign rs2        = head_instr[24:20];
    assign rd         = head_instr[11:7];

    always_comb begin
        dec_aluop     = AluAdd;
        dec_cmpop     = 3'd0;
        dec_alumux1   = 1'b0;
        dec_alumux2   = Mux2Iimm;
        dec_cmpmux    = 1'b0;
        dec_rfmux     = RfAlu;
        dec_pcmux     = PcPlus4;
        dec_load_rf   = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_illegal   = 1'b0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        is_load       = 1'b0;
        case (opcode)
            OpReg, OpImm: begin
                uses_rs1    = 1'b1;
                uses_rs2    = (opcode == OpReg);
                dec_load_rf = 1'b1;
                dec_alumux2 = (opcode == OpReg) ? Mux2Rs2 : Mux2Iimm;
                // slt/sltu reuse the branch comparator and write br_en back
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_rfmux  = RfBrEn;
                    dec_cmpop  = (funct3 == 3'b010) ? CmpBlt : CmpBltu;
                    dec_cmpmux = (opcode == OpImm);
                end else begin
                    dec_aluop = alu_from_funct3(funct3, funct7_5, opcode == OpReg);
                end
            end
            OpLoad: begin
                uses_rs1     = 1'b1;
                is_load      = 1'b1;
                dec_mem_read = 1'b1;
                dec_rfmux    = RfLoad;
                dec_load_rf  = 1'b1;
            end
            OpStore: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                dec_alumux2   = Mux2Simm;
                dec_mem_write = 1'b1;
            end
            OpBr: begin
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                dec_alumux1 = 1'b1;
                dec_alumux2 = Mux2Bimm;
                dec_pcmux   = PcBranch;
                dec_cmpop   = funct3;
            end
            OpLui: begin
                dec_rfmux   = RfUimm;
                dec_load_rf = 1'b1;
            end
            OpAuipc: begin
                dec_alumux1 = 1'b1;
                dec_alumux2 = Mux2Uimm;
                dec_load_rf = 1'b1;
            end
            OpJal: begin
                dec_alumux1 = 1'b1;
                dec_alumux2 = Mux2Jimm;
                dec_pcmux   = PcBranch;
                dec_rfmux   = RfPc4;
                dec_load_rf = 1'b1;
            end
            OpJalr: begin
                uses_rs1    = 1'b1;
                dec_pcmux   = PcJalr;
                dec_rfmux   = RfPc4;
                dec_load_rf = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (rd == 5'd0) begin
            dec_load_rf = 1'b0;
        end
    end

    assign bubble   = lu_armed_q && head_valid &&
                      ((uses_rs1 && rs1 == lu_rd_q) || (uses_rs2 && rs2 == lu_rd_q));
    assign if_ready = (count_q < FullCnt) && !rst;
    assign id_valid = head_valid && !bubble && !flush && !rst;
    assign push     = if_valid && if_ready && !flush;
    assign pop      = id_valid && id_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        lu_armed_d = 1'b0;
        lu_rd_d    = 5'd0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                // Arm for exactly one cycle; any non-load pop or idle cycle disarms
                if (is_load && rd != 5'd0) begin
                    lu_armed_d = 1'b1;
                    lu_rd_d    = rd;
                end
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lu_armed_q <= 1'b0;
            lu_rd_q    <= 5'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lu_armed_q <= lu_armed_d;
            lu_rd_q    <= lu_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= if_instr;
            pc_mem_q[wr_ptr_q]    <= if_pc;
        end
    end

    always_comb begin
        id_pc             = 32'd0;
        id_instr          = 32'd0;
        id_rs1            = 5'd0;
        id_rs2            = 5'd0;
        id_rd             = 5'd0;
        id_aluop          = 3'd0;
        id_cmpop          = 3'd0;
        id_alumux1_sel    = 1'b0;
        id_alumux2_sel    = 3'd0;
        id_cmpmux_sel     = 1'b0;
        id_regfilemux_sel = 3'd0;
        id_pcmux_sel      = 2'd0;
        id_load_regfile   = 1'b0;
        id_mem_read       = 1'b0;
        id_mem_write      = 1'b0;
        id_funct3         = 3'd0;
        id_illegal        = 1'b0;
        if (id_valid) begin
            id_pc             = head_pc;
            id_instr          = head_instr;
            id_rs1            = rs1;
            id_rs2            = rs2;
            id_rd             = rd;
            id_aluop          = dec_aluop;
            id_cmpop          = dec_cmpop;
            id_alumux1_sel    = dec_alumux1;
            id_alumux2_sel    = dec_alumux2;
            id_cmpmux_sel     = dec_cmpmux;
            id_regfilemux_sel = dec_rfmux;
            id_pcmux_sel      = dec_pcmux;
            id_load_regfile   = dec_load_rf;
            id_mem_read       = dec_mem_read;
            id_mem_write      = dec_mem_write;
            id_funct3         = funct3;
            id_illegal        = dec_illegal;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cnt_issued_q, cnt_bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_issued_q <= '0;
            cnt_bubble_q <= '0;
        end else begin
            if (pop) begin
                cnt_issued_q <= cnt_issued_q + 1'b1;
            end
            if (bubble && !flush) begin
                cnt_bubble_q <= cnt_bubble_q + 1'b1;
            end
        end
    end

    assign cnt_issued = cnt_issued_q;
    assign cnt_bubble = cnt_bubble_q;
`endif

endmodule
